// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses SYNC/LEN/PAYLOAD/CHK frames from a UART byte strobe,
// buffers the payload and releases it on a valid/ready stream once verified.
module uart_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 32,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] byte_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       last_out,
    output logic       frame_ok_out,
    output logic       frame_err_out,
    output logic [1:0] err_code_out,
    output logic       overrun_out
);

    localparam int W  = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);
    localparam logic [W-1:0]  ONE      = W'(1);

    localparam logic [1:0] E_CHK     = 2'd0;
    localparam logic [1:0] E_LEN     = 2'd1;
    localparam logic [1:0] E_TIMEOUT = 2'd2;
    localparam logic [1:0] E_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHECK,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic [W-1:0]  len_q, len_n;
    logic [W-1:0]  wr_idx, wr_n;
    logic [W-1:0]  rd_idx, rd_n;
    logic [W-1:0]  len_m1;
    logic [7:0]    chk, chk_n;
    logic [TW-1:0] idle_cnt, idle_n;
    logic [1:0]    code_n;
    logic          ok_n, err_n, ovr_n;
    logic          we;
    logic          timeout;

    logic [7:0] mem [MAX_LEN];

    assign len_m1  = len_q - ONE;
    assign timeout = !valid_in && (idle_cnt == IDLE_MAX);

    assign valid_out = (state == DRAIN);
    assign last_out  = valid_out && (rd_idx == len_m1);
    assign data_out  = valid_out ? mem[rd_idx[AW-1:0]] : 8'h00;

    always_comb begin
        state_n = state;
        len_n   = len_q;
        wr_n    = wr_idx;
        rd_n    = rd_idx;
        chk_n   = chk;
        code_n  = err_code_out;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        ovr_n   = 1'b0;
        we      = 1'b0;
        idle_n  = '0;

        // idle counter only runs while a frame is being assembled
        if ((state == LEN || state == PAYLOAD || state == CHECK) && !valid_in)
            idle_n = idle_cnt + TW'(1);

        unique case (state)
            HUNT: begin
                if (valid_in && byte_in == SYNC_BYTE)
                    state_n = LEN;
            end
            LEN: begin
                if (valid_in) begin
                    if (byte_in == 8'h00 || byte_in > LEN_MAX) begin
                        err_n   = 1'b1;
                        code_n  = E_LEN;
                        state_n = HUNT;
                    end else begin
                        len_n   = byte_in[W-1:0];
                        chk_n   = byte_in;
                        wr_n    = '0;
                        state_n = PAYLOAD;
                    end
                end else if (timeout) begin
                    err_n   = 1'b1;
                    code_n  = E_TIMEOUT;
                    state_n = HUNT;
                end
            end
            PAYLOAD: begin
                if (valid_in) begin
                    we    = 1'b1;
                    chk_n = chk ^ byte_in;
                    wr_n  = wr_idx + ONE;
                    if (wr_idx == len_m1)
                        state_n = CHECK;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    code_n  = E_TIMEOUT;
                    state_n = HUNT;
                end
            end
            CHECK: begin
                if (valid_in) begin
                    if (byte_in == chk) begin
                        ok_n    = 1'b1;
                        rd_n    = '0;
                        state_n = DRAIN;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = E_CHK;
                        state_n = HUNT;
                    end
                end else if (timeout) begin
                    err_n   = 1'b1;
                    code_n  = E_TIMEOUT;
                    state_n = HUNT;
                end
            end
            DRAIN: begin
                if (ready_in) begin
                    rd_n = rd_idx + ONE;
                    if (rd_idx == len_m1)
                        state_n = HUNT;
                end
                // no backpressure upstream: bytes arriving now are lost
                if (valid_in) begin
                    ovr_n = 1'b1;
                    if (byte_in == SYNC_BYTE) begin
                        err_n  = 1'b1;
                        code_n = E_OVERRUN;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= HUNT;
            len_q         <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            chk           <= '0;
            idle_cnt      <= '0;
            err_code_out  <= 2'd0;
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            state         <= state_n;
            len_q         <= len_n;
            wr_idx        <= wr_n;
            rd_idx        <= rd_n;
            chk           <= chk_n;
            idle_cnt      <= idle_n;
            err_code_out  <= code_n;
            frame_ok_out  <= ok_n;
            frame_err_out <= err_n;
            overrun_out   <= ovr_n;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we)
            mem[wr_idx[AW-1:0]] <= byte_in;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: table vectors, directed corner sequences and a randomized
// stream checked against a frame-level reference parser.
module tb_uart_frame_rx;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int ML = 32;
    localparam int T  = 300;

    logic       clk;
    logic       rst_in;
    logic [7:0] byte_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       last_out;
    logic       frame_ok_out;
    logic       frame_err_out;
    logic [1:0] err_code_out;
    logic       overrun_out;

    uart_frame_rx #(
        .SYNC_BYTE(SYNC),
        .MAX_LEN(ML),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .byte_in(byte_in),
        .valid_in(valid_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .last_out(last_out),
        .frame_ok_out(frame_ok_out),
        .frame_err_out(frame_err_out),
        .err_code_out(err_code_out),
        .overrun_out(overrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // observed traffic
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_c[$];
    int         got_e[$];
    int         ok_cnt = 0;
    int         ovr_cnt = 0;
    int         stalls = 0;
    int         cyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_in) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", int'(valid_out), 1);
                check("stall_data", int'(data_out), int'(pd));
                check("stall_last", int'(last_out), int'(pl));
            end
            stall_prev = valid_out && !ready_in;
            if (stall_prev) stalls++;
            pd = data_out;
            pl = last_out;
            if (valid_out && ready_in) begin
                got_d.push_back(data_out);
                got_l.push_back(last_out);
                got_c.push_back(cyc);
            end
            if (frame_ok_out) begin
                ok_cnt++;
                check("ok_err_exclusive", int'(frame_err_out), 0);
            end
            if (frame_err_out) got_e.push_back(int'(err_code_out));
            if (overrun_out) ovr_cnt++;
        end
    end

    // ready_in driver: 0 low, 1 high, 2 pattern 1,0,0,1, 3 random
    int rmode = 1;
    initial begin
        int k;
        k = 0;
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: ready_in = 1'b0;
                1: ready_in = 1'b1;
                2: ready_in = (k % 4 == 0) || (k % 4 == 3);
                default: ready_in = 1'($urandom);
            endcase
            k++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in  = b;
        valid_in = 1'b1;
        step(1);
        valid_in = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) begin
            send(q[i]);
            if (maxgap > 0) step($urandom_range(0, maxgap));
        end
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (got_d.size() < n && t < 2000) begin
            step(1);
            t++;
        end
        step(2);
    endtask

    task automatic clear_obs();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        got_e.delete();
        ok_cnt = 0;
        ovr_cnt = 0;
    endtask

    // frame-level reference parser
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    int         exp_e[$];
    int         exp_ok = 0;

    function automatic void model(input logic [7:0] q[$]);
        int i;
        int len;
        logic [7:0] x;
        i = 0;
        while (i < q.size()) begin
            if (q[i] != SYNC) begin
                i++;
            end else if (i + 1 >= q.size()) begin
                i = q.size();
            end else begin
                len = int'(q[i+1]);
                if (len == 0 || len > ML) begin
                    exp_e.push_back(1);
                    i += 2;
                end else if (i + 2 + len >= q.size()) begin
                    i = q.size();
                end else begin
                    x = q[i+1];
                    for (int k = 0; k < len; k++) x ^= q[i+2+k];
                    if (q[i+2+len] == x) begin
                        exp_ok++;
                        for (int k = 0; k < len; k++) begin
                            exp_d.push_back(q[i+2+k]);
                            exp_l.push_back(k == len - 1);
                        end
                    end else begin
                        exp_e.push_back(0);
                    end
                    i += 3 + len;
                end
            end
        end
    endfunction

    typedef struct {
        logic [0:7][7:0] b;
        int n;
        int off;
        int ok;
        int err;
        int code;
        int nout;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [7:0] q[$];
        logic [7:0] x;
        int len;
        int kind;

        vt[0] = '{{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h03,8'h00,8'h00}, 6, 2, 1, 0, 0, 3};
        vt[1] = '{{8'hA5,8'h02,8'h10,8'h20,8'h00,8'h00,8'h00,8'h00}, 5, 2, 0, 1, 0, 0};
        vt[2] = '{{8'hA5,8'h01,8'h7E,8'h7F,8'h00,8'h00,8'h00,8'h00}, 4, 2, 1, 0, 0, 1};
        vt[3] = '{{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 2, 0, 1, 1, 0};
        vt[4] = '{{8'hA5,8'h21,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 2, 0, 1, 1, 0};
        vt[5] = '{{8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 2, 0, 0, 0, 0};
        vt[6] = '{{8'h5A,8'hA5,8'h02,8'hAA,8'h55,8'hFD,8'h00,8'h00}, 6, 3, 1, 0, 0, 2};
        vt[7] = '{{8'hA5,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 2, 0, 1, 1, 0};
        vt[8] = '{{8'hA5,8'h01,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00}, 4, 2, 1, 0, 0, 1};
        vt[9] = '{{8'hA5,8'h01,8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00}, 4, 2, 0, 1, 0, 0};

        rst_in   = 1'b1;
        valid_in = 1'b0;
        byte_in  = 8'h00;
        step(2);
        check("rst_valid", int'(valid_out), 0);
        check("rst_last", int'(last_out), 0);
        check("rst_ok", int'(frame_ok_out), 0);
        check("rst_err", int'(frame_err_out), 0);
        check("rst_ovr", int'(overrun_out), 0);
        check("rst_code", int'(err_code_out), 0);
        check("rst_data", int'(data_out), 0);
        rst_in = 1'b0;
        step(2);

        // table vectors, ready held high
        rmode = 1;
        foreach (vt[i]) begin
            clear_obs();
            for (int j = 0; j < vt[i].n; j++) send(vt[i].b[j]);
            if (vt[i].nout > 0) wait_out(vt[i].nout);
            else step(6);
            check($sformatf("v%0d_ok", i), ok_cnt, vt[i].ok);
            check($sformatf("v%0d_err", i), got_e.size(), vt[i].err);
            if (vt[i].err > 0 && got_e.size() > 0)
                check($sformatf("v%0d_code", i), got_e[0], vt[i].code);
            check($sformatf("v%0d_nout", i), got_d.size(), vt[i].nout);
            for (int j = 0; j < vt[i].nout && j < got_d.size(); j++) begin
                check($sformatf("v%0d_d%0d", i, j), int'(got_d[j]),
                      int'(vt[i].b[vt[i].off + j]));
                check($sformatf("v%0d_l%0d", i, j), int'(got_l[j]),
                      int'(j == vt[i].nout - 1));
                if (j > 0)
                    check($sformatf("v%0d_gap%0d", i, j), got_c[j] - got_c[j-1], 1);
            end
        end

        // maximum length frame
        clear_obs();
        q.delete();
        q.push_back(SYNC);
        q.push_back(8'(ML));
        x = 8'(ML);
        for (int k = 0; k < ML; k++) begin
            q.push_back(8'(k * 7 + 1));
            x ^= 8'(k * 7 + 1);
        end
        q.push_back(x);
        send_q(q, 0);
        wait_out(ML);
        check("max_ok", ok_cnt, 1);
        check("max_err", got_e.size(), 0);
        check("max_nout", got_d.size(), ML);
        for (int k = 0; k < ML && k < got_d.size(); k++) begin
            check($sformatf("max_d%0d", k), int'(got_d[k]), (k * 7 + 1) & 255);
            check($sformatf("max_l%0d", k), int'(got_l[k]), int'(k == ML - 1));
        end

        // backpressure 1,0,0,1
        clear_obs();
        stalls = 0;
        rmode = 2;
        q = '{SYNC, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        x = 8'h04 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        q.push_back(x);
        send_q(q, 0);
        wait_out(4);
        check("bp_stalls_seen", int'(stalls > 0), 1);
        check("bp_nout", got_d.size(), 4);
        for (int k = 0; k < 4 && k < got_d.size(); k++) begin
            check($sformatf("bp_d%0d", k), int'(got_d[k]), int'(q[k+2]));
            check($sformatf("bp_l%0d", k), int'(got_l[k]), int'(k == 3));
        end
        rmode = 1;
        step(2);

        // junk then timeout
        clear_obs();
        q = '{8'h00, 8'hFF, SYNC, 8'h02, 8'h44};
        send_q(q, 0);
        step(T - 2);
        check("to_early", got_e.size(), 0);
        step(4);
        check("to_err", got_e.size(), 1);
        if (got_e.size() > 0) check("to_code", got_e[0], 2);
        q = '{SYNC, 8'h01, 8'h7E, 8'h7F};
        send_q(q, 0);
        wait_out(1);
        check("to_next_ok", ok_cnt, 1);
        check("to_next_nout", got_d.size(), 1);
        if (got_d.size() > 0) check("to_next_d", int'(got_d[0]), 8'h7E);
        step(T + 10);
        check("to_hunt_quiet", got_e.size(), 1);

        // byte arriving on the last idle cycle wins over the timeout
        clear_obs();
        send(SYNC);
        step(T - 1);
        send(8'h02);
        step(T - 1);
        send(8'h44);
        step(T - 1);
        send(8'h55);
        step(T - 1);
        send(8'h13);
        wait_out(2);
        check("edge_err", got_e.size(), 0);
        check("edge_ok", ok_cnt, 1);
        check("edge_nout", got_d.size(), 2);
        if (got_d.size() > 1) check("edge_d1", int'(got_d[1]), 8'h55);

        // reset mid-payload, then mid-drain
        clear_obs();
        send_q('{SYNC, 8'h04, 8'h01, 8'h02}, 0);
        rst_in = 1'b1;
        #1;
        check("rstp_code", int'(err_code_out), 0);
        check("rstp_valid", int'(valid_out), 0);
        check("rstp_err", int'(frame_err_out), 0);
        step(2);
        rst_in = 1'b0;
        rmode = 0;
        step(1);
        send_q('{SYNC, 8'h02, 8'h12, 8'h34, 8'h24}, 0);
        step(3);
        check("rstd_pre_valid", int'(valid_out), 1);
        check("rstd_pre_data", int'(data_out), 8'h12);
        rst_in = 1'b1;
        #1;
        check("rstd_valid", int'(valid_out), 0);
        check("rstd_last", int'(last_out), 0);
        check("rstd_data", int'(data_out), 0);
        step(1);
        rst_in = 1'b0;
        rmode = 1;
        step(1);
        clear_obs();
        send_q('{SYNC, 8'h01, 8'h7E, 8'h7F}, 0);
        wait_out(1);
        check("rst_next_ok", ok_cnt, 1);
        check("rst_next_err", got_e.size(), 0);
        check("rst_next_nout", got_d.size(), 1);
        if (got_d.size() > 0) check("rst_next_d", int'(got_d[0]), 8'h7E);

        // overrun during a stalled drain
        clear_obs();
        rmode = 0;
        step(1);
        send_q('{SYNC, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDE}, 0);
        step(2);
        check("ovr_pre_valid", int'(valid_out), 1);
        check("ovr_pre_data", int'(data_out), 8'hAA);
        send(SYNC);
        step(2);
        check("ovr_cnt1", ovr_cnt, 1);
        check("ovr_err", got_e.size(), 1);
        if (got_e.size() > 0) check("ovr_code", got_e[0], 3);
        send(8'h11);
        step(2);
        check("ovr_cnt2", ovr_cnt, 2);
        check("ovr_err_once", got_e.size(), 1);
        check("ovr_code_held", int'(err_code_out), 3);
        rmode = 1;
        wait_out(3);
        check("ovr_nout", got_d.size(), 3);
        for (int k = 0; k < 3 && k < got_d.size(); k++) begin
            check($sformatf("ovr_d%0d", k), int'(got_d[k]), 8'hAA + 17 * k);
            check($sformatf("ovr_l%0d", k), int'(got_l[k]), int'(k == 2));
        end

        // randomized stream against the reference parser
        clear_obs();
        exp_d.delete();
        exp_l.delete();
        exp_e.delete();
        exp_ok = 0;
        rmode = 3;
        for (int f = 0; f < 40; f++) begin
            q.delete();
            repeat ($urandom_range(0, 2)) begin
                x = 8'($urandom);
                if (x == SYNC) x = 8'h00;
                q.push_back(x);
            end
            kind = $urandom_range(0, 3);
            q.push_back(SYNC);
            if (kind == 0) begin
                len = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(ML + 1, 255);
                q.push_back(8'(len));
            end else begin
                len = $urandom_range(1, ML);
                q.push_back(8'(len));
                x = 8'(len);
                for (int k = 0; k < len; k++) begin
                    q.push_back(8'($urandom));
                    x ^= q[q.size() - 1];
                end
                if (kind == 1) x ^= 8'($urandom_range(1, 255));
                q.push_back(x);
            end
            model(q);
            send_q(q, 3);
            wait_out(exp_d.size());
        end
        step(4);
        check("rnd_ok", ok_cnt, exp_ok);
        check("rnd_ovr", ovr_cnt, 0);
        check("rnd_nerr", got_e.size(), exp_e.size());
        for (int k = 0; k < exp_e.size() && k < got_e.size(); k++)
            check($sformatf("rnd_e%0d", k), got_e[k], exp_e[k]);
        check("rnd_nout", got_d.size(), exp_d.size());
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            check($sformatf("rnd_d%0d", k), int'(got_d[k]), int'(exp_d[k]));
            check($sformatf("rnd_l%0d", k), int'(got_l[k]), int'(exp_l[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Sits directly downstream of the UART receiver. Consumes its one-cycle byte/valid pulses and parses framed packets of the form SYNC, LEN, PAYLOAD[LEN], CHK.
- Buffers the payload and forwards it on a valid/ready byte stream only after the checksum verifies. Corrupt or timed-out frames are discarded and reported on status pulses.
- Feeds the command/data logic that follows the serial link.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 32, maximum payload bytes; sets buffer depth. Legal range 1..255.
- TIMEOUT_CYCLES, 100_000, maximum clk_in cycles allowed between bytes inside a frame (1 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  asynchronous active-high reset.
- byte_in  input  8  received byte from the UART receiver.
- valid_in  input  1  one-cycle strobe qualifying byte_in. No backpressure toward the receiver.
- data_out  output  8  payload byte.
- valid_out  output  1  data_out valid.
- ready_in  input  1  downstream accepts data_out this cycle.
- last_out  output  1  marks the final payload byte of a frame, qualified by valid_out.
- frame_ok_out  output  1  one-cycle pulse when a frame's checksum passes.
- frame_err_out  output  1  one-cycle pulse when a frame is discarded.
- err_code_out  output  2  reason for the error: 0 bad checksum, 1 bad length, 2 timeout, 3 overrun. Held until the next frame_err_out.
- overrun_out  output  1  one-cycle pulse for each byte dropped during DRAIN.

Behaviour:
- Reset (async assert, release synchronous to clk_in):
  - state = HUNT.
  - valid_out = 0, last_out = 0, frame_ok_out = 0, frame_err_out = 0, overrun_out = 0.
  - err_code_out = 0, data_out = 0.
  - All counters and the running checksum cleared.
  - Reset mid-frame or mid-drain discards everything.
- Checksum: 8-bit XOR of LEN and every payload byte. The frame passes when CHK equals that XOR.
- States:
  - HUNT: ignore any byte not equal to SYNC_BYTE. On SYNC_BYTE, go to LEN.
  - LEN: if the byte is 0 or greater than MAX_LEN, pulse frame_err_out with code 1 and go to HUNT. Otherwise store LEN, set chk = LEN, wr_idx = 0, go to PAYLOAD.
  - PAYLOAD: write the byte to buf[wr_idx], chk ^= byte, wr_idx++. When wr_idx reaches LEN-1 and a byte is written, go to CHECK.
  - CHECK: on a byte equal to chk, pulse frame_ok_out, set rd_idx = 0, go to DRAIN. On mismatch, pulse frame_err_out with code 0 and go to HUNT.
  - DRAIN: valid_out = 1 and data_out = buf[rd_idx]. last_out = 1 when rd_idx == LEN-1. On valid_out && ready_in, rd_idx++. After the last handshake, deassert valid_out and go to HUNT in the same cycle.
- Output stream rules:
  - data_out and last_out are stable while valid_out is high and ready_in is low.
  - Maximum throughput is one byte per cycle.
  - The first valid_out rises one cycle after the CHK byte is sampled.
- Timeout:
  - An idle counter resets on every valid_in and increments otherwise.
  - In LEN, PAYLOAD or CHECK, reaching TIMEOUT_CYCLES-1 pulses frame_err_out with code 2 and returns to HUNT.
  - The counter is inactive in HUNT and DRAIN.
- Overrun: a valid_in during DRAIN drops the byte and pulses overrun_out.
  - If the dropped byte is SYNC_BYTE, also pulse frame_err_out with code 3. That next frame is lost; the block does not resync mid-drain.
  - Draining continues unaffected.
- Simultaneous events:
  - A timeout and a valid_in in the same cycle: the byte wins and the counter resets.
  - Status pulses last exactly one cycle. frame_ok_out and frame_err_out are never high together.
- Widths: wr_idx, rd_idx and LEN are $clog2(MAX_LEN+1) bits. The buffer is a MAX_LEN x 8 register or distributed-RAM array with synchronous write and combinational read.

Test Plan:
- Good frame: A5 03 11 22 33 03 (chk = 03^11^22^33 = 03), ready_in held 1 → one frame_ok_out pulse; data_out 11, 22, 33 on consecutive valid cycles; last_out only on 33; no frame_err_out.
- Bad checksum: A5 02 10 20 00 → frame_err_out with err_code_out = 0; valid_out never asserts. A following good frame parses normally.
- Length bounds: A5 00, then A5 21 with MAX_LEN = 32 → frame_err_out with code 1 for each. Then A5 20 followed by 32 bytes and correct chk → 32 output bytes, last_out on byte 32.
- Backpressure: good 4-byte frame with ready_in toggling 1,0,0,1,… → data_out and last_out stable while stalled; exactly 4 handshakes in order.
- Timeout/junk: bytes 00 FF then A5 02 44, then silence for TIMEOUT_CYCLES → junk ignored; frame_err_out with code 2 once; next A5 01 7E 7F accepted (chk = 01^7E = 7F).
- Reset/overrun: assert rst_in mid-PAYLOAD → outputs at reset values immediately, next frame parses clean. Separately, hold ready_in = 0 during DRAIN and send A5 → overrun_out pulses and frame_err_out with code 3; original payload still drains intact.
